// File: rtl/msrv32_dmem_pkg.sv
// Shared types and constants for the data-memory access sequencer.
package msrv32_dmem_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned MASK_W = XLEN / 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUS  = 2'b01,
    ST_RESP = 2'b10
  } state_e;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // Request qualifiers kept for the duration of a bus transfer
  typedef struct packed {
    logic       is_store;
    logic [1:0] addr_lo;
    logic [1:0] size;
    logic       is_unsigned;
  } req_info_t;

  // Size 2'b11 is treated as a word access
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SZ_BYTE: is_misaligned = 1'b0;
      SZ_HALF: is_misaligned = addr_lo[0];
      default: is_misaligned = (addr_lo != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/msrv32_store_align.sv
// Byte-lane enable and lane-replicated write data for a store.
module msrv32_store_align
  import msrv32_dmem_pkg::*;
(
  input  logic [1:0]        addr_lo,
  input  logic [1:0]        size,
  input  logic [XLEN-1:0]   wdata,
  output logic [MASK_W-1:0] mask_c,
  output logic [XLEN-1:0]   data_c
);

  always_comb begin
    mask_c = 4'b1111;
    data_c = wdata;
    case (size)
      SZ_BYTE: begin
        mask_c = 4'b0001 << addr_lo;
        data_c = {4{wdata[7:0]}};
      end
      SZ_HALF: begin
        mask_c = addr_lo[1] ? 4'b1100 : 4'b0011;
        data_c = {2{wdata[15:0]}};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/msrv32_dmem_ctrl.sv
// Data-memory access sequencer: one request at a time, alignment check,
// bus handshake with wait states/timeout, registered response.
module msrv32_dmem_ctrl
  import msrv32_dmem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned TO_W           = 5
) (
  input  logic              ms_riscv32_mp_clk_in,
  input  logic              ms_riscv32_mp_rst_n_in,
  input  logic              req_valid_in,
  output logic              req_ready_out,
  input  logic              req_is_store_in,
  input  logic [XLEN-1:0]   req_addr_in,
  input  logic [XLEN-1:0]   req_wdata_in,
  input  logic [1:0]        req_size_in,
  input  logic              req_unsigned_in,
  output logic [XLEN-1:0]   ms_riscv32_mp_dmaddr_out,
  output logic              ms_riscv32_mp_dmrd_req_out,
  output logic              ms_riscv32_mp_dmwr_req_out,
  output logic [MASK_W-1:0] ms_riscv32_mp_dmwr_mask_out,
  output logic [XLEN-1:0]   ms_riscv32_mp_dmdata_out,
  input  logic [XLEN-1:0]   ms_riscv32_mp_dmdata_in,
  input  logic              ms_riscv32_mp_dm_ready_in,
  input  logic              ms_riscv32_mp_dm_err_in,
  output logic              resp_valid_out,
  output logic [XLEN-1:0]   resp_rdata_out,
  output logic [1:0]        resp_addr_1_to_0_out,
  output logic [1:0]        resp_size_out,
  output logic              resp_unsigned_out,
  output logic              resp_err_out,
  output logic              resp_misaligned_out,
  output logic              stall_out
);

  state_e            state;
  req_info_t         req_q;
  logic [TO_W-1:0]   to_cnt;
  logic [MASK_W-1:0] align_mask_c;
  logic [XLEN-1:0]   align_data_c;
  logic              accept_c;
  logic              misaligned_c;
  logic              timeout_c;
  logic              bus_done_c;
  logic              bus_err_c;

  msrv32_store_align u_store_align (
    .addr_lo (req_addr_in[1:0]),
    .size    (req_size_in),
    .wdata   (req_wdata_in),
    .mask_c  (align_mask_c),
    .data_c  (align_data_c)
  );

  assign req_ready_out = (state == ST_IDLE);
  assign stall_out     = (state != ST_IDLE);
  assign accept_c      = req_valid_in && req_ready_out;
  assign misaligned_c  = is_misaligned(req_size_in, req_addr_in[1:0]);
  assign timeout_c     = (TIMEOUT_CYCLES != 0) &&
                         (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
  // Error is only meaningful with ready; a timeout is always an error
  assign bus_done_c    = ms_riscv32_mp_dm_ready_in || timeout_c;
  assign bus_err_c     = ms_riscv32_mp_dm_ready_in ? ms_riscv32_mp_dm_err_in : 1'b1;

  always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_n_in) begin
    if (!ms_riscv32_mp_rst_n_in) begin
      state                       <= ST_IDLE;
      req_q                       <= '0;
      to_cnt                      <= '0;
      ms_riscv32_mp_dmaddr_out    <= '0;
      ms_riscv32_mp_dmrd_req_out  <= 1'b0;
      ms_riscv32_mp_dmwr_req_out  <= 1'b0;
      ms_riscv32_mp_dmwr_mask_out <= '0;
      ms_riscv32_mp_dmdata_out    <= '0;
      resp_valid_out              <= 1'b0;
      resp_rdata_out              <= '0;
      resp_addr_1_to_0_out        <= '0;
      resp_size_out               <= '0;
      resp_unsigned_out           <= 1'b0;
      resp_err_out                <= 1'b0;
      resp_misaligned_out         <= 1'b0;
    end else begin
      resp_valid_out <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept_c && misaligned_c) begin
            state                <= ST_RESP;
            resp_valid_out       <= 1'b1;
            resp_rdata_out       <= '0;
            resp_addr_1_to_0_out <= req_addr_in[1:0];
            resp_size_out        <= req_size_in;
            resp_unsigned_out    <= req_unsigned_in;
            resp_err_out         <= 1'b0;
            resp_misaligned_out  <= 1'b1;
          end else if (accept_c) begin
            state                       <= ST_BUS;
            req_q                       <= '{is_store:    req_is_store_in,
                                             addr_lo:     req_addr_in[1:0],
                                             size:        req_size_in,
                                             is_unsigned: req_unsigned_in};
            to_cnt                      <= '0;
            ms_riscv32_mp_dmaddr_out    <= {req_addr_in[XLEN-1:2], 2'b00};
            ms_riscv32_mp_dmrd_req_out  <= !req_is_store_in;
            ms_riscv32_mp_dmwr_req_out  <= req_is_store_in;
            ms_riscv32_mp_dmwr_mask_out <= req_is_store_in ? align_mask_c : '0;
            ms_riscv32_mp_dmdata_out    <= req_is_store_in ? align_data_c : '0;
          end
        end
        ST_BUS: begin
          if (bus_done_c) begin
            state                       <= ST_RESP;
            ms_riscv32_mp_dmrd_req_out  <= 1'b0;
            ms_riscv32_mp_dmwr_req_out  <= 1'b0;
            ms_riscv32_mp_dmwr_mask_out <= '0;
            ms_riscv32_mp_dmdata_out    <= '0;
            resp_valid_out              <= 1'b1;
            resp_rdata_out              <= (!req_q.is_store && !bus_err_c) ?
                                           ms_riscv32_mp_dmdata_in : '0;
            resp_addr_1_to_0_out        <= req_q.addr_lo;
            resp_size_out               <= req_q.size;
            resp_unsigned_out           <= req_q.is_unsigned;
            resp_err_out                <= bus_err_c;
            resp_misaligned_out         <= 1'b0;
          end else if (to_cnt != {TO_W{1'b1}}) begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_msrv32_dmem_ctrl.sv
// Directed bench for msrv32_dmem_ctrl: per-cycle transaction model plus literal checks.
module tb_msrv32_dmem_ctrl;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req_valid = 1'b0, req_is_store = 1'b0, req_unsigned = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [1:0]  req_size = '0;
  logic [31:0] dmdata_in = '0;
  logic        dm_ready = 1'b0, dm_err = 1'b0;

  logic        req_ready, rd_req, wr_req, resp_valid, resp_uns, resp_err, resp_mis, stall;
  logic [31:0] dmaddr, dmdata_out, resp_rdata;
  logic [3:0]  wr_mask;
  logic [1:0]  resp_alo, resp_size;

  msrv32_dmem_ctrl #(.TIMEOUT_CYCLES(TO), .TO_W(5)) dut (
    .ms_riscv32_mp_clk_in        (clk),
    .ms_riscv32_mp_rst_n_in      (rst_n),
    .req_valid_in                (req_valid),
    .req_ready_out               (req_ready),
    .req_is_store_in             (req_is_store),
    .req_addr_in                 (req_addr),
    .req_wdata_in                (req_wdata),
    .req_size_in                 (req_size),
    .req_unsigned_in             (req_unsigned),
    .ms_riscv32_mp_dmaddr_out    (dmaddr),
    .ms_riscv32_mp_dmrd_req_out  (rd_req),
    .ms_riscv32_mp_dmwr_req_out  (wr_req),
    .ms_riscv32_mp_dmwr_mask_out (wr_mask),
    .ms_riscv32_mp_dmdata_out    (dmdata_out),
    .ms_riscv32_mp_dmdata_in     (dmdata_in),
    .ms_riscv32_mp_dm_ready_in   (dm_ready),
    .ms_riscv32_mp_dm_err_in     (dm_err),
    .resp_valid_out              (resp_valid),
    .resp_rdata_out              (resp_rdata),
    .resp_addr_1_to_0_out        (resp_alo),
    .resp_size_out               (resp_size),
    .resp_unsigned_out           (resp_uns),
    .resp_err_out                (resp_err),
    .resp_misaligned_out         (resp_mis),
    .stall_out                   (stall)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        ready, stall, rd, wr;
    logic [31:0] addr;
    logic [3:0]  mask;
    logic [31:0] data;
    logic        rv;
    logic [31:0] rdata;
    logic [1:0]  alo, size;
    logic        uns, err, mis;
  } exp_t;

  exp_t exp;
  logic exp_on = 1'b0;
  int   n_chk = 0, n_fail = 0;

  // Observations from the latest transaction
  int          lat, nstall, nact;
  logic [3:0]  got_mask;
  logic [31:0] got_data, got_rdata;
  logic        got_err, got_mis;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Compare DUT against the model on every cycle
  always @(negedge clk) begin
    if (exp_on) begin
      chk("req_ready", 32'(req_ready), 32'(exp.ready));
      chk("stall", 32'(stall), 32'(exp.stall));
      chk("rd_req", 32'(rd_req), 32'(exp.rd));
      chk("wr_req", 32'(wr_req), 32'(exp.wr));
      chk("resp_valid", 32'(resp_valid), 32'(exp.rv));
      chk("resp_rdata", resp_rdata, exp.rdata);
      chk("resp_alo", 32'(resp_alo), 32'(exp.alo));
      chk("resp_size", 32'(resp_size), 32'(exp.size));
      chk("resp_unsigned", 32'(resp_uns), 32'(exp.uns));
      chk("resp_err", 32'(resp_err), 32'(exp.err));
      chk("resp_mis", 32'(resp_mis), 32'(exp.mis));
      if (exp.rd || exp.wr) begin
        chk("dmaddr", dmaddr, exp.addr);
        chk("wr_mask", 32'(wr_mask), 32'(exp.mask));
        chk("dmdata_out", dmdata_out, exp.data);
      end
    end
  end

  task automatic set_idle();
    exp.ready = 1'b1; exp.stall = 1'b0; exp.rd = 1'b0; exp.wr = 1'b0; exp.rv = 1'b0;
  endtask

  task automatic sample(input int i);
    if (resp_valid && lat == 0) lat = i;
    if (stall) nstall++;
    if (rd_req || wr_req) nact++;
    if (i == 1) begin got_mask = wr_mask; got_data = dmdata_out; end
    if (resp_valid) begin got_rdata = resp_rdata; got_err = resp_err; got_mis = resp_mis; end
  endtask

  // waits < 0 means dm_ready is never given
  task automatic do_txn(input logic st, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [1:0] sz, input logic uns, input int waits,
                        input logic err, input logic [31:0] rd);
    int nbytes, nbus;
    logic mis, tmo, last;
    logic [3:0] m;
    logic [31:0] d;
    nbytes = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    mis    = (addr % nbytes) != 0;
    tmo    = (waits < 0) || (waits >= TO);
    nbus   = mis ? 0 : (tmo ? TO : waits + 1);
    if (!st)              begin m = 4'h0; d = 32'h0; end
    else if (nbytes == 1) begin m = 4'(1 << (addr % 4)); d = {24'h0, wd[7:0]} * 32'h0101_0101; end
    else if (nbytes == 2) begin m = ((addr % 4) >= 2) ? 4'hC : 4'h3; d = {16'h0, wd[15:0]} * 32'h0001_0001; end
    else                  begin m = 4'hF; d = wd; end
    lat = 0; nstall = 0; nact = 0; got_mask = '0; got_data = '0;
    got_rdata = '0; got_err = 1'b0; got_mis = 1'b0;

    @(posedge clk); #1;
    req_valid = 1'b1; req_is_store = st; req_addr = addr; req_wdata = wd;
    req_size = sz; req_unsigned = uns; dm_ready = 1'b0; dm_err = 1'b0;
    set_idle();
    @(negedge clk);
    @(posedge clk); #1;
    // Scramble request inputs: the DUT must use latched values
    req_valid = 1'b0; req_is_store = ~st; req_addr = ~addr; req_wdata = ~wd;
    req_size = ~sz; req_unsigned = ~uns;
    for (int i = 1; i <= nbus; i++) begin
      last      = !tmo && (i == nbus);
      dm_ready  = last;
      dm_err    = last ? err : 1'b1;
      dmdata_in = last ? rd : (32'hDEAD_0000 | 32'(i));
      exp.ready = 1'b0; exp.stall = 1'b1; exp.rd = !st; exp.wr = st; exp.rv = 1'b0;
      exp.addr  = addr & 32'hFFFF_FFFC; exp.mask = m; exp.data = d;
      @(negedge clk); sample(i);
      @(posedge clk); #1;
    end
    dm_ready = 1'b0; dm_err = 1'b0; dmdata_in = '0;
    exp.ready = 1'b0; exp.stall = 1'b1; exp.rd = 1'b0; exp.wr = 1'b0; exp.rv = 1'b1;
    exp.rdata = (!st && !mis && !tmo && !err) ? rd : 32'h0;
    exp.alo = addr[1:0]; exp.size = sz; exp.uns = uns;
    exp.err = !mis && (tmo || err); exp.mis = mis;
    @(negedge clk); sample(nbus + 1);
    @(posedge clk); #1;
    set_idle();
    @(negedge clk); sample(nbus + 2);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    exp = '0; exp.ready = 1'b1; exp_on = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("reset_ready", 32'(req_ready), 32'd1);
    chk("reset_stall", 32'(stall), 32'd0);

    // 1: load word, zero wait states
    do_txn(1'b0, 32'h100, 32'h0, 2'b10, 1'b0, 0, 1'b0, 32'h1234_5678);
    chk("t1_lat", 32'(lat), 32'd2);
    chk("t1_rdata", got_rdata, 32'h1234_5678);
    chk("t1_nact", 32'(nact), 32'd1);

    // 2: store byte 0xA5 at 0x203, 3 wait cycles
    do_txn(1'b1, 32'h203, 32'h0000_00A5, 2'b00, 1'b0, 3, 1'b0, 32'h0);
    chk("t2_mask", 32'(got_mask), 32'h8);
    chk("t2_data", got_data, 32'hA5A5_A5A5);
    chk("t2_lat", 32'(lat), 32'd5);
    chk("t2_stall", 32'(nstall), 32'd5);
    chk("t2_nact", 32'(nact), 32'd4);

    // 3: misaligned half and word loads
    do_txn(1'b0, 32'h101, 32'h0, 2'b01, 1'b0, 0, 1'b0, 32'hFFFF_FFFF);
    chk("t3a_lat", 32'(lat), 32'd1);
    chk("t3a_mis", 32'(got_mis), 32'd1);
    chk("t3a_nact", 32'(nact), 32'd0);
    do_txn(1'b0, 32'h102, 32'h0, 2'b10, 1'b1, 0, 1'b0, 32'hFFFF_FFFF);
    chk("t3b_lat", 32'(lat), 32'd1);
    chk("t3b_mis", 32'(got_mis), 32'd1);

    // 4: load never acknowledged -> timeout
    do_txn(1'b0, 32'h400, 32'h0, 2'b10, 1'b0, -1, 1'b0, 32'h0);
    chk("t4_lat", 32'(lat), 32'd17);
    chk("t4_err", 32'(got_err), 32'd1);
    chk("t4_nact", 32'(nact), 32'd16);

    // 5: store half with bus error
    do_txn(1'b1, 32'h302, 32'h0000_BEEF, 2'b01, 1'b0, 0, 1'b1, 32'h5555_5555);
    chk("t5_mask", 32'(got_mask), 32'hC);
    chk("t5_data", got_data, 32'hBEEF_BEEF);
    chk("t5_err", 32'(got_err), 32'd1);
    chk("t5_rdata", got_rdata, 32'h0);

    // Extra patterns: unsigned byte load, half load with waits, size 11, load error
    do_txn(1'b0, 32'h0FF, 32'h0, 2'b00, 1'b1, 1, 1'b0, 32'hCAFE_F00D);
    do_txn(1'b0, 32'h106, 32'h0, 2'b01, 1'b0, 2, 1'b0, 32'h8765_4321);
    do_txn(1'b1, 32'h010, 32'h1357_9BDF, 2'b11, 1'b0, 0, 1'b0, 32'h0);
    chk("x_w3_mask", 32'(got_mask), 32'hF);
    do_txn(1'b1, 32'h011, 32'h1357_9BDF, 2'b11, 1'b0, 0, 1'b0, 32'h0);
    do_txn(1'b0, 32'h204, 32'h0, 2'b10, 1'b0, 1, 1'b1, 32'h7777_7777);
    chk("x_lderr_rdata", got_rdata, 32'h0);

    // 6: reset in the 2nd wait cycle of a load
    @(posedge clk); #1;
    req_valid = 1'b1; req_is_store = 1'b0; req_addr = 32'h500; req_size = 2'b10;
    req_unsigned = 1'b0; dm_ready = 1'b0; dm_err = 1'b0;
    set_idle();
    @(posedge clk); #1;
    req_valid = 1'b0;
    exp.ready = 1'b0; exp.stall = 1'b1; exp.rd = 1'b1; exp.wr = 1'b0;
    exp.addr = 32'h500; exp.mask = 4'h0; exp.data = 32'h0;
    @(posedge clk); #1;
    #2 rst_n = 1'b0;
    exp = '0; exp.ready = 1'b1;
    #1;
    chk("t6_rd_drop", 32'(rd_req), 32'd0);
    chk("t6_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    chk("t6_no_resp", 32'(resp_valid), 32'd0);
    rst_n = 1'b1;
    do_txn(1'b0, 32'h600, 32'h0, 2'b10, 1'b0, 0, 1'b0, 32'h0BAD_BEEF);
    chk("t6_after_lat", 32'(lat), 32'd2);
    chk("t6_after_rdata", got_rdata, 32'h0BAD_BEEF);

    @(posedge clk); #1;
    exp_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
